// File: rtl/mii_frame_gen_pkg.sv
// Shared types and constants for the MII/GMII frame generator.
// Section sequencing lives here so the FSM and any later checker agree on it.
package mii_gen_pkg;

  localparam int         DEF_LEN_W     = 17;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    PAY,
    IPG
  } gen_state_e;

  // Frame sections always run in the order PRE -> SFD -> PAY -> IPG.
  function automatic gen_state_e next_section(input gen_state_e s);
    case (s)
      PRE:     return SFD;
      SFD:     return PAY;
      PAY:     return IPG;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mii_frame_gen_if.sv
// Request/stream bundle between a frame generator and whoever drives or watches it.
// Signal names match the PCS testbench harness so existing scoreboards can bind directly.
interface mii_frame_gen_if
  import mii_gen_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W
);

  logic             GBspeed;
  logic             start;
  logic [LEN_W-1:0] len_in;
  logic [7:0]       seed_in;
  logic             err_en;
  logic [LEN_W-1:0] err_pos;

  logic [7:0]       data_out;
  logic             dv_out;
  logic             err_out;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] len_out;
  logic             len_wr;

  modport master (
    output GBspeed, start, len_in, seed_in, err_en, err_pos,
    input  data_out, dv_out, err_out, busy, done, len_out, len_wr
  );

  modport slave (
    input  GBspeed, start, len_in, seed_in, err_en, err_pos,
    output data_out, dv_out, err_out, busy, done, len_out, len_wr
  );

endinterface

// File: rtl/mii_nibble_tx.sv
// Registered byte-to-line stage: one beat per byte in GMII, low/high nibble beats in MII.
// byte_done_o flags that the beat now on the line is the last beat of its byte.
module mii_nibble_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       gb_i,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  input  logic       err_i,
  input  logic       valid_i,
  output logic [7:0] data_o,
  output logic       dv_o,
  output logic       err_o,
  output logic       byte_done_o
);

  logic [3:0] hi_q;
  logic       gb_q;
  logic       half_q;
  logic       active_q;
  logic [7:0] data_q;
  logic       dv_q;
  logic       err_q;

  assign byte_done_o = active_q & (gb_q | half_q);

  // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q     <= '0;
      gb_q     <= 1'b0;
      half_q   <= 1'b0;
      active_q <= 1'b0;
      data_q   <= '0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else if (load_i) begin
      hi_q     <= byte_i[7:4];
      gb_q     <= gb_i;
      half_q   <= 1'b0;
      active_q <= 1'b1;
      data_q   <= gb_i ? byte_i : {4'h0, byte_i[3:0]};
      dv_q     <= valid_i;
      err_q    <= err_i;
    end else if (active_q && !byte_done_o) begin
      // Second MII beat: dv and err stay as loaded.
      half_q   <= 1'b1;
      data_q   <= {4'h0, hi_q};
    end else begin
      active_q <= 1'b0;
      half_q   <= 1'b0;
      data_q   <= '0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
    end
  end

  assign data_o = data_q;
  assign dv_o   = dv_q;
  assign err_o  = err_q;

endmodule

// File: rtl/mii_frame_gen.sv
// Frame transmitter: preamble, SFD, counting payload and IPG, with optional error injection.
// state_q always names the section of the byte currently held in the line stage.
module mii_frame_gen
  import mii_gen_pkg::*;
#(
  parameter int LEN_W        = DEF_LEN_W,
  parameter int PREAMBLE_LEN = 7,
  parameter int IPG_BYTES    = 12
) (
  input  logic           clk,
  input  logic           rst,
  mii_frame_gen_if.slave bus
);

  localparam logic [LEN_W-1:0] PRE_LAST = LEN_W'(PREAMBLE_LEN - 1);
  localparam logic [LEN_W-1:0] IPG_LAST = LEN_W'(IPG_BYTES - 1);
  localparam logic [LEN_W-1:0] IPG_PEN  = LEN_W'(IPG_BYTES - 2);

  gen_state_e       state_q, state_d, nxt_state;
  logic [LEN_W-1:0] cnt_q, cnt_d, nxt_cnt;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       seed_q, seed_d;
  logic             err_en_q, err_en_d;
  logic [LEN_W-1:0] err_pos_q, err_pos_d;
  logic             speed_q, speed_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] len_out_q, len_out_d;
  logic             len_wr_q, len_wr_d;

  logic       tx_load, tx_err, tx_valid, tx_gb, tx_byte_done;
  logic [7:0] tx_byte;
  logic       sect_last, ipg_end;

  // Speed is taken live only for the very first byte; after that the latched copy rules.
  assign tx_gb = (state_q == IDLE) ? bus.GBspeed : speed_q;

  // The final IPG beat carries no data, so the FSM drops to IDLE as that beat is launched:
  // done coincides with the last idle beat and a start then lands with exactly IPG between.
  assign ipg_end = (state_q == IPG) &&
                   (speed_q ? (tx_byte_done && cnt_q == IPG_PEN)
                            : (!tx_byte_done && cnt_q == IPG_LAST));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    seed_d    = seed_q;
    err_en_d  = err_en_q;
    err_pos_d = err_pos_q;
    speed_d   = speed_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    len_out_d = len_out_q;
    len_wr_d  = 1'b0;
    tx_load   = 1'b0;
    tx_byte   = '0;
    tx_err    = 1'b0;
    tx_valid  = 1'b0;

    unique case (state_q)
      PRE:     sect_last = (cnt_q == PRE_LAST);
      SFD:     sect_last = 1'b1;
      PAY:     sect_last = (cnt_q == len_q - LEN_W'(1));
      default: sect_last = 1'b0;
    endcase
    nxt_state = sect_last ? next_section(state_q) : state_q;
    nxt_cnt   = sect_last ? '0 : cnt_q + LEN_W'(1);

    if (state_q == IDLE) begin
      if (bus.start && bus.len_in != '0) begin
        state_d   = PRE;
        cnt_d     = '0;
        len_d     = bus.len_in;
        seed_d    = bus.seed_in;
        err_en_d  = bus.err_en;
        err_pos_d = bus.err_pos;
        speed_d   = bus.GBspeed;
        busy_d    = 1'b1;
        tx_load   = 1'b1;
        tx_byte   = PREAMBLE_BYTE;
        tx_valid  = 1'b1;
      end
    end else if (ipg_end) begin
      state_d = IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end else if (tx_byte_done) begin
      state_d = nxt_state;
      cnt_d   = nxt_cnt;
      tx_load = 1'b1;
      case (nxt_state)
        PRE: begin
          tx_byte  = PREAMBLE_BYTE;
          tx_valid = 1'b1;
        end
        SFD: begin
          tx_byte  = SFD_BYTE;
          tx_valid = 1'b1;
        end
        PAY: begin
          // nxt_cnt < len here, so an err_pos at or beyond len can never match.
          tx_byte  = seed_q + nxt_cnt[7:0];
          tx_err   = err_en_q && (nxt_cnt == err_pos_q);
          tx_valid = 1'b1;
        end
        default: ;
      endcase
      if (state_q == PAY && sect_last) begin
        len_wr_d  = 1'b1;
        len_out_d = len_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      seed_q    <= '0;
      err_en_q  <= 1'b0;
      err_pos_q <= '0;
      speed_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      len_out_q <= '0;
      len_wr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      seed_q    <= seed_d;
      err_en_q  <= err_en_d;
      err_pos_q <= err_pos_d;
      speed_q   <= speed_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      len_out_q <= len_out_d;
      len_wr_q  <= len_wr_d;
    end
  end

  mii_nibble_tx u_tx (
    .clk        (clk),
    .rst        (rst),
    .gb_i       (tx_gb),
    .load_i     (tx_load),
    .byte_i     (tx_byte),
    .err_i      (tx_err),
    .valid_i    (tx_valid),
    .data_o     (bus.data_out),
    .dv_o       (bus.dv_out),
    .err_o      (bus.err_out),
    .byte_done_o(tx_byte_done)
  );

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.len_out = len_out_q;
  assign bus.len_wr  = len_wr_q;

endmodule

// File: tb/tb_mii_frame_gen.sv
// Directed bench for mii_frame_gen: a table of frames with hand-computed results,
// plus sequences for ignored starts, back-to-back frames and mid-frame reset.
module tb_mii_frame_gen;

  localparam int LEN_W = 17;

  typedef struct {
    bit         gb;
    int         len;
    logic [7:0] seed;
    bit         err_en;
    int         err_pos;
    int         exp_dv;
    int         exp_ipg;
    int         exp_err;
    logic [7:0] exp_err_data;
    logic [7:0] exp_last;
  } vec_t;

  typedef struct {
    logic             first_ok;
    int               bad;
    int               dv_clks;
    int               ipg_clks;
    int               err_clks;
    int               done_k;
    int               wr_cnt;
    int               wr_k;
    logic [7:0]       err_data;
    logic [7:0]       last_data;
    logic [LEN_W-1:0] len_o;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  mii_frame_gen_if #(.LEN_W(LEN_W)) bus ();

  mii_frame_gen #(.LEN_W(LEN_W), .PREAMBLE_LEN(7), .IPG_BYTES(12)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit gb, input int len, input logic [7:0] seed,
                              input bit err_en, input int err_pos, input int exp_dv,
                              input int exp_ipg, input int exp_err,
                              input logic [7:0] exp_err_data, input logic [7:0] exp_last);
    vec_t v;
    v.gb = gb; v.len = len; v.seed = seed; v.err_en = err_en; v.err_pos = err_pos;
    v.exp_dv = exp_dv; v.exp_ipg = exp_ipg; v.exp_err = exp_err;
    v.exp_err_data = exp_err_data; v.exp_last = exp_last;
    return v;
  endfunction

  // Reference byte stream of a frame: 7 x 55, D5, then seed, seed+1, ...
  function automatic logic [7:0] model_byte(input vec_t v, input int b);
    if (b < 7)  return 8'h55;
    if (b == 7) return 8'hD5;
    return v.seed + 8'(b - 8);
  endfunction

  task automatic run_frame(input vec_t v, input int spur_k, output res_t r);
    int         n_beats;
    int         b;
    logic [7:0] eb;
    logic [7:0] exp_data;
    logic       exp_dv, exp_err;
    n_beats     = (8 + v.len) * (v.gb ? 1 : 2);
    r.first_ok  = 1'b0;
    r.bad       = 0;
    r.dv_clks   = 0;
    r.ipg_clks  = 0;
    r.err_clks  = 0;
    r.done_k    = -1;
    r.wr_cnt    = 0;
    r.wr_k      = -1;
    r.err_data  = '0;
    r.last_data = '0;
    r.len_o     = '0;
    bus.GBspeed = v.gb;
    bus.len_in  = LEN_W'(v.len);
    bus.seed_in = v.seed;
    bus.err_en  = v.err_en;
    bus.err_pos = LEN_W'(v.err_pos);
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (k == spur_k) begin
        bus.start   = 1'b1;
        bus.len_in  = LEN_W'(5);
        bus.GBspeed = ~v.gb;
      end else begin
        bus.start = 1'b0;
      end
      b        = v.gb ? k : k / 2;
      eb       = model_byte(v, b);
      exp_dv   = (k < n_beats);
      exp_data = !exp_dv ? 8'h00 : (v.gb ? eb : ((k % 2 == 0) ? {4'h0, eb[3:0]} : {4'h0, eb[7:4]}));
      exp_err  = exp_dv && v.err_en && (v.err_pos < v.len) && (b == 8 + v.err_pos);
      if (k == 0)
        r.first_ok = bus.busy && bus.dv_out && (bus.data_out == (v.gb ? 8'h55 : 8'h05));
      if (bus.dv_out !== exp_dv || bus.data_out !== exp_data || bus.err_out !== exp_err ||
          bus.busy !== ~bus.done)
        r.bad++;
      if (bus.dv_out) begin
        r.dv_clks++;
        r.last_data = bus.data_out;
      end else begin
        r.ipg_clks++;
      end
      if (bus.err_out) begin
        if (r.err_clks == 0) r.err_data = bus.data_out;
        r.err_clks++;
      end
      if (bus.len_wr) begin
        r.wr_cnt++;
        r.wr_k  = k;
        r.len_o = bus.len_out;
      end
      if (bus.done) begin
        r.done_k = k;
        break;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic check_frame(input string tag, input vec_t v, input res_t r);
    check({tag, "_first_beat"}, 32'(r.first_ok), 32'd1);
    check({tag, "_beat_errs"},  r.bad,            0);
    check({tag, "_dv_clks"},    r.dv_clks,        v.exp_dv);
    check({tag, "_ipg_clks"},   r.ipg_clks,       v.exp_ipg);
    check({tag, "_err_clks"},   r.err_clks,       v.exp_err);
    if (v.exp_err > 0)
      check({tag, "_err_data"}, 32'(r.err_data),  32'(v.exp_err_data));
    check({tag, "_last_data"},  32'(r.last_data), 32'(v.exp_last));
    check({tag, "_done_clk"},   r.done_k,         v.exp_dv + v.exp_ipg - 1);
    check({tag, "_len_wr_cnt"}, r.wr_cnt,         1);
    check({tag, "_len_wr_clk"}, r.wr_k,           v.exp_dv);
    check({tag, "_len_out"},    32'(r.len_o),     32'(v.len));
  endtask

  vec_t vecs[6];
  res_t r1, r2;
  int   quiet;

  initial begin
    // gb, len, seed, err_en, err_pos, dv clks, ipg clks, err clks, err data, last data
    vecs[0] = mk(1'b1, 4, 8'hFE, 1'b0, 0, 12, 12, 0, 8'h00, 8'h01);
    vecs[1] = mk(1'b0, 2, 8'hA3, 1'b0, 0, 20, 24, 0, 8'h00, 8'h0A);
    vecs[2] = mk(1'b1, 8, 8'h10, 1'b1, 3, 16, 12, 1, 8'h13, 8'h17);
    vecs[3] = mk(1'b1, 8, 8'h10, 1'b1, 8, 16, 12, 0, 8'h00, 8'h17);
    vecs[4] = mk(1'b0, 3, 8'hFF, 1'b1, 2, 22, 24, 2, 8'h01, 8'h00);
    vecs[5] = mk(1'b1, 1, 8'h00, 1'b1, 0,  9, 12, 1, 8'h00, 8'h00);

    bus.GBspeed = 1'b1;
    bus.start   = 1'b0;
    bus.len_in  = '0;
    bus.seed_in = '0;
    bus.err_en  = 1'b0;
    bus.err_pos = '0;

    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.data_out, bus.dv_out, bus.err_out, bus.busy, bus.done, bus.len_wr}, 0);
    check("reset_len_out", 32'(bus.len_out), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      run_frame(vecs[i], -1, r1);
      check_frame($sformatf("vec%0d", i), vecs[i], r1);
      repeat (3) @(negedge clk);
    end

    // Start with len_in == 0 must be ignored.
    bus.len_in = '0;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    quiet = 0;
    for (int k = 0; k < 4; k++) begin
      quiet += int'(bus.busy | bus.dv_out | bus.len_wr);
      @(negedge clk);
    end
    check("len0_ignored", quiet, 0);

    // Start (with other len, flipped speed) while busy must not disturb the running frame.
    run_frame(vecs[0], 3, r1);
    check_frame("busy_start", vecs[0], r1);
    quiet = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      quiet += int'(bus.busy | bus.dv_out | bus.len_wr);
    end
    check("no_extra_frame", quiet, 0);

    // Back-to-back: second start issued during the done clk.
    run_frame(vecs[0], -1, r1);
    run_frame(vecs[0], -1, r2);
    check_frame("b2b_first", vecs[0], r1);
    check_frame("b2b_second", vecs[0], r2);
    check("b2b_gap", r1.ipg_clks, 12);
    repeat (3) @(negedge clk);

    // Reset in the middle of a long payload.
    bus.GBspeed = 1'b1;
    bus.len_in  = LEN_W'(20);
    bus.seed_in = 8'h00;
    bus.err_en  = 1'b0;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_reset_dv", 32'(bus.dv_out), 1);
    check("pre_reset_data", 32'(bus.data_out), 32'h02);
    rst = 1'b1;
    #1;
    check("mid_reset_outputs", {bus.data_out, bus.dv_out, bus.err_out, bus.busy, bus.done, bus.len_wr}, 0);
    check("mid_reset_len_out", 32'(bus.len_out), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    quiet = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      quiet += int'(bus.busy | bus.dv_out | bus.len_wr);
    end
    check("post_reset_quiet", quiet, 0);
    run_frame(vecs[0], -1, r1);
    check_frame("post_reset", vecs[0], r1);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
